// File: rtl/branch_predictor_ctrl.sv
// -----------------------------------------------------------------------------
// branch_predictor_ctrl
//
// Bimodal branch predictor with misprediction recovery. A table of
// 2**IDX_W two-bit saturating counters, indexed by the low address bits,
// answers fetch-stage prediction requests with one cycle of latency. Branch
// outcomes from execute train the table. A wrong prediction raises a flush
// with the corrected fetch address, which is held until the pipeline
// acknowledges it.
//
// Ports
//   clock, reset_n      : single rising-edge clock, async active-low reset
//   predict_req/addr    : prediction request from fetch
//   predict_ready       : request accepted when high together with predict_req
//   predict_valid/taken : one-cycle pulse carrying the predicted direction
//   resolve_*           : executed branch outcome (addr, target, taken, pred)
//   resolve_ready       : outcome accepted when high together with resolve_valid
//   flush/redirect_addr : flush request and corrected fetch address
//   flush_ack           : pipeline has completed the flush
//   mispredict_count    : saturating count of mispredictions since reset
// -----------------------------------------------------------------------------
module branch_predictor_ctrl #(
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              predict_req,
    input  logic [ADDR_W-1:0] predict_addr,
    output logic              predict_ready,
    output logic              predict_valid,
    output logic              predict_taken,
    input  logic              resolve_valid,
    input  logic [ADDR_W-1:0] resolve_addr,
    input  logic [ADDR_W-1:0] resolve_target,
    input  logic              resolve_taken,
    input  logic              resolve_pred,
    output logic              resolve_ready,
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_addr,
    input  logic              flush_ack,
    output logic [15:0]       mispredict_count
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        UPDATE     = 2'd1,
        FLUSH_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          ctr_q [DEPTH];
    logic [1:0]          ctr_d [DEPTH];
    logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
    logic [ADDR_W-1:0]   cap_target_q, cap_target_d;
    logic                cap_taken_q, cap_taken_d;
    logic                cap_pred_q, cap_pred_d;
    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic                flush_q, flush_d;
    logic [ADDR_W-1:0]   redirect_q, redirect_d;
    logic [15:0]         mis_cnt_q, mis_cnt_d;
    logic [IDX_W-1:0]    upd_idx;

    // Resolve has priority: fetch is held off whenever an outcome is pending.
    assign resolve_ready    = (state_q == IDLE);
    assign predict_ready    = (state_q == IDLE) && !resolve_valid;

    assign predict_valid    = pred_valid_q;
    assign predict_taken    = pred_taken_q;
    assign flush            = flush_q;
    assign redirect_addr    = redirect_q;
    assign mispredict_count = mis_cnt_q;

    assign upd_idx = cap_addr_q[IDX_W-1:0];

    // Predictions are only accepted in IDLE and the table is only written in
    // UPDATE, so a read always sees the registered (pre-update) counter.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        ctr_d        = ctr_q;
        cap_addr_d   = cap_addr_q;
        cap_target_d = cap_target_q;
        cap_taken_d  = cap_taken_q;
        cap_pred_d   = cap_pred_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        flush_d      = flush_q;
        redirect_d   = redirect_q;
        mis_cnt_d    = mis_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (resolve_valid) begin
                    cap_addr_d   = resolve_addr;
                    cap_target_d = resolve_target;
                    cap_taken_d  = resolve_taken;
                    cap_pred_d   = resolve_pred;
                    state_d      = UPDATE;
                end else if (predict_req) begin
                    pred_valid_d = 1'b1;
                    pred_taken_d = ctr_q[predict_addr[IDX_W-1:0]][1];
                end
            end

            UPDATE: begin
                if (cap_taken_q && (ctr_q[upd_idx] != 2'd3)) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                end else if (!cap_taken_q && (ctr_q[upd_idx] != 2'd0)) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
                end

                if (cap_taken_q == cap_pred_q) begin
                    state_d = IDLE;
                end else begin
                    flush_d    = 1'b1;
                    // Not-taken recovery resumes at the fall-through address,
                    // wrapping at the top of the address space.
                    redirect_d = cap_taken_q ? cap_target_q
                                             : cap_addr_q + ADDR_W'(1);
                    if (mis_cnt_q != 16'hFFFF) begin
                        mis_cnt_d = mis_cnt_q + 16'd1;
                    end
                    state_d = FLUSH_WAIT;
                end
            end

            FLUSH_WAIT: begin
                if (flush_ack) begin
                    flush_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: the counter table lives in flops rather than RAM because every
    // entry must return to weakly-not-taken asynchronously on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= 2'b01;
            end
            cap_addr_q   <= '0;
            cap_target_q <= '0;
            cap_taken_q  <= 1'b0;
            cap_pred_q   <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
            mis_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            ctr_q        <= ctr_d;
            cap_addr_q   <= cap_addr_d;
            cap_target_q <= cap_target_d;
            cap_taken_q  <= cap_taken_d;
            cap_pred_q   <= cap_pred_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            flush_q      <= flush_d;
            redirect_q   <= redirect_d;
            mis_cnt_q    <= mis_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_ctrl
//
// Table-driven bench for branch_predictor_ctrl. Predictions are scored through
// a queue: the expected direction and arrival cycle are pushed when a request
// is accepted and popped when predict_valid pulses. Resolve vectors check the
// flush, redirect address and misprediction count. Hand-written sequences
// cover the predict/resolve conflict and reset during FLUSH_WAIT.
// -----------------------------------------------------------------------------
module tb_branch_predictor_ctrl;

    localparam int IDX_W  = 4;
    localparam int ADDR_W = 11;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              predict_req = 1'b0;
    logic [ADDR_W-1:0] predict_addr = '0;
    logic              predict_ready;
    logic              predict_valid;
    logic              predict_taken;
    logic              resolve_valid = 1'b0;
    logic [ADDR_W-1:0] resolve_addr = '0;
    logic [ADDR_W-1:0] resolve_target = '0;
    logic              resolve_taken = 1'b0;
    logic              resolve_pred = 1'b0;
    logic              resolve_ready;
    logic              flush;
    logic [ADDR_W-1:0] redirect_addr;
    logic              flush_ack = 1'b0;
    logic [15:0]       mispredict_count;

    branch_predictor_ctrl #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .predict_req      (predict_req),
        .predict_addr     (predict_addr),
        .predict_ready    (predict_ready),
        .predict_valid    (predict_valid),
        .predict_taken    (predict_taken),
        .resolve_valid    (resolve_valid),
        .resolve_addr     (resolve_addr),
        .resolve_target   (resolve_target),
        .resolve_taken    (resolve_taken),
        .resolve_pred     (resolve_pred),
        .resolve_ready    (resolve_ready),
        .flush            (flush),
        .redirect_addr    (redirect_addr),
        .flush_ack        (flush_ack),
        .mispredict_count (mispredict_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard of outstanding predictions.
    typedef struct {
        logic              taken;
        int                cyc;
        logic [ADDR_W-1:0] addr;
    } sb_t;
    sb_t exp_q[$];

    always @(negedge clock) begin
        sb_t e;
        if (reset_n && predict_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected predict_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("predict_taken @0x%03h", e.addr), predict_taken, e.taken);
                check($sformatf("predict latency @0x%03h", e.addr), cyc, e.cyc);
            end
        end
    end

    // Vector table.
    typedef struct {
        bit                is_res;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] target;
        bit                taken;
        bit                pred;
        bit                exp_bit;   // predicted direction, or flush expected
        logic [ADDR_W-1:0] exp_redir;
        logic [15:0]       exp_cnt;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    function automatic vec_t mk_p(input logic [ADDR_W-1:0] a, input bit t);
        vec_t v;
        v = '{is_res: 1'b0, addr: a, target: '0, taken: 1'b0, pred: 1'b0,
              exp_bit: t, exp_redir: '0, exp_cnt: '0};
        return v;
    endfunction

    function automatic vec_t mk_r(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] tgt,
                                  input bit tk, input bit pd, input bit fl,
                                  input logic [ADDR_W-1:0] rd, input logic [15:0] cnt);
        vec_t v;
        v = '{is_res: 1'b1, addr: a, target: tgt, taken: tk, pred: pd,
              exp_bit: fl, exp_redir: rd, exp_cnt: cnt};
        return v;
    endfunction

    task automatic do_predict(input logic [ADDR_W-1:0] a, input bit exp_t);
        int tries = 0;
        @(negedge clock);
        predict_req  = 1'b1;
        predict_addr = a;
        #1;
        while (!predict_ready && tries < 50) begin
            @(negedge clock);
            #1;
            tries++;
        end
        if (!predict_ready) begin
            check("predict_ready timeout", 0, 1);
            predict_req = 1'b0;
            return;
        end
        exp_q.push_back('{taken: exp_t, cyc: cyc + 1, addr: a});
        @(posedge clock);
        #1 predict_req = 1'b0;
    endtask

    task automatic do_resolve(input vec_t v);
        int tries = 0;
        logic [ADDR_W-1:0] held;
        @(negedge clock);
        resolve_valid  = 1'b1;
        resolve_addr   = v.addr;
        resolve_target = v.target;
        resolve_taken  = v.taken;
        resolve_pred   = v.pred;
        #1;
        while (!resolve_ready && tries < 50) begin
            @(negedge clock);
            #1;
            tries++;
        end
        if (!resolve_ready) begin
            check("resolve_ready timeout", 0, 1);
            resolve_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1 resolve_valid = 1'b0;
        @(negedge clock);                       // UPDATE cycle
        check($sformatf("resolve_ready in UPDATE @0x%03h", v.addr), resolve_ready, 0);
        @(negedge clock);                       // after the update edge
        check($sformatf("flush @0x%03h", v.addr), flush, v.exp_bit);
        check($sformatf("mispredict_count @0x%03h", v.addr), mispredict_count, v.exp_cnt);
        if (v.exp_bit) begin
            check($sformatf("redirect_addr @0x%03h", v.addr), redirect_addr, v.exp_redir);
            held = redirect_addr;
            repeat (2) begin
                @(negedge clock);
                check("flush held", flush, 1);
                check("redirect held", redirect_addr, held);
                check("resolve_ready in FLUSH_WAIT", resolve_ready, 0);
            end
            flush_ack = 1'b1;
            @(posedge clock);
            #1 flush_ack = 1'b0;
            @(negedge clock);
            check("flush cleared by ack", flush, 0);
            check("IDLE after ack", resolve_ready, 1);
        end else begin
            check($sformatf("IDLE after update @0x%03h", v.addr), resolve_ready, 1);
        end
    endtask

    initial begin
        // Counters start at 01; IDX_W = 4, so 0x015 aliases 0x005 and 0x7FF
        // aliases 0x00F.
        vecs[0]  = mk_p(11'h005, 1'b0);
        vecs[1]  = mk_r(11'h005, 11'h000, 1, 1, 0, 11'h000, 16'd0);   // 01->10
        vecs[2]  = mk_r(11'h005, 11'h000, 1, 1, 0, 11'h000, 16'd0);   // 10->11
        vecs[3]  = mk_r(11'h005, 11'h000, 1, 1, 0, 11'h000, 16'd0);   // 11 sat
        vecs[4]  = mk_p(11'h005, 1'b1);
        vecs[5]  = mk_p(11'h015, 1'b1);
        vecs[6]  = mk_r(11'h7FF, 11'h123, 0, 1, 1, 11'h000, 16'd1);   // F: 01->00
        vecs[7]  = mk_p(11'h00F, 1'b0);
        vecs[8]  = mk_r(11'h010, 11'h2A0, 1, 0, 1, 11'h2A0, 16'd2);   // 0: 01->10
        vecs[9]  = mk_p(11'h000, 1'b1);
        vecs[10] = mk_r(11'h005, 11'h000, 0, 1, 1, 11'h006, 16'd3);   // 5: 11->10
        vecs[11] = mk_p(11'h005, 1'b1);
        vecs[12] = mk_r(11'h005, 11'h000, 0, 0, 0, 11'h000, 16'd3);   // 5: 10->01
        vecs[13] = mk_p(11'h005, 1'b0);
        vecs[14] = mk_r(11'h00F, 11'h000, 0, 0, 0, 11'h000, 16'd3);   // F: 00 sat
        vecs[15] = mk_p(11'h00F, 1'b0);
        vecs[16] = mk_r(11'h00F, 11'h7FE, 1, 0, 1, 11'h7FE, 16'd4);   // F: 00->01
        vecs[17] = mk_p(11'h00F, 1'b0);

        // Reset state.
        #1;
        check("reset predict_valid", predict_valid, 0);
        check("reset predict_taken", predict_taken, 0);
        check("reset flush", flush, 0);
        check("reset redirect_addr", redirect_addr, 0);
        check("reset mispredict_count", mispredict_count, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("ready after reset (predict)", predict_ready, 1);
        check("ready after reset (resolve)", resolve_ready, 1);

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].is_res) do_resolve(vecs[i]);
            else                do_predict(vecs[i].addr, vecs[i].exp_bit);
        end

        // Conflict: resolve wins, prediction waits for the return to IDLE.
        // Counter 0 is 10 from the table, so the delayed prediction is taken.
        @(negedge clock);
        predict_req    = 1'b1;
        predict_addr   = 11'h000;
        resolve_valid  = 1'b1;
        resolve_addr   = 11'h003;
        resolve_target = 11'h000;
        resolve_taken  = 1'b1;
        resolve_pred   = 1'b1;
        #1;
        check("conflict resolve_ready", resolve_ready, 1);
        check("conflict predict_ready", predict_ready, 0);
        @(posedge clock);
        #1 resolve_valid = 1'b0;
        @(negedge clock);
        #1;
        check("conflict predict_ready in UPDATE", predict_ready, 0);
        check("conflict no predict_valid", predict_valid, 0);
        @(negedge clock);
        #1;
        check("conflict predict_ready back in IDLE", predict_ready, 1);
        exp_q.push_back('{taken: 1'b1, cyc: cyc + 1, addr: 11'h000});
        @(posedge clock);
        #1 predict_req = 1'b0;

        // Reset while in FLUSH_WAIT.
        @(negedge clock);
        resolve_valid  = 1'b1;
        resolve_addr   = 11'h005;
        resolve_target = 11'h100;
        resolve_taken  = 1'b1;
        resolve_pred   = 1'b0;
        #1;
        check("pre-reset resolve_ready", resolve_ready, 1);
        @(posedge clock);
        #1 resolve_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("pre-reset flush", flush, 1);
        check("pre-reset mispredict_count", mispredict_count, 5);
        #2 reset_n = 1'b0;
        #1;
        check("async reset flush", flush, 0);
        check("async reset mispredict_count", mispredict_count, 0);
        check("async reset redirect_addr", redirect_addr, 0);
        check("async reset state IDLE", resolve_ready, 1);
        @(negedge clock);
        reset_n = 1'b1;
        do_predict(11'h005, 1'b0);   // was 10 before reset
        do_predict(11'h000, 1'b0);   // was 10 before reset
        do_predict(11'h003, 1'b0);   // was 10 before reset

        repeat (3) @(negedge clock);
        check("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/branch_predictor_ctrl.md
BRANCH_PREDICTOR_CTRL -- requirements
Module: branch_predictor_ctrl

Interface
REQ-001 SHALL provide parameter IDX_W, default 4, predictor table index width (table depth 2**IDX_W).
REQ-002 SHALL provide parameter ADDR_W, default 11, program address width.
REQ-003 SHALL provide port: clock  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL provide port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port: predict_req  input  1  fetch stage requests a prediction.
REQ-006 SHALL provide port: predict_addr  input  ADDR_W  address of the branch being fetched.
REQ-007 SHALL provide port: predict_ready  output  1  prediction request accepted this cycle when high together with predict_req.
REQ-008 SHALL provide port: predict_valid  output  1  one-cycle pulse, predict_taken valid.
REQ-009 SHALL provide port: predict_taken  output  1  predicted direction.
REQ-010 SHALL provide port: resolve_valid  input  1  executed branch outcome present (from the latched exec_done).
REQ-011 SHALL provide port: resolve_addr  input  ADDR_W  address of the resolved branch.
REQ-012 SHALL provide port: resolve_target  input  ADDR_W  jump target of the resolved branch.
REQ-013 SHALL provide port: resolve_taken  input  1  actual direction.
REQ-014 SHALL provide port: resolve_pred  input  1  direction that was predicted for this branch.
REQ-015 SHALL provide port: resolve_ready  output  1  outcome accepted this cycle when high together with resolve_valid.
REQ-016 SHALL provide port: flush  output  1  pipeline flush request, level, held until acknowledged.
REQ-017 SHALL provide port: redirect_addr  output  ADDR_W  corrected fetch address, valid while flush high.
REQ-018 SHALL provide port: flush_ack  input  1  pipeline has completed the flush.
REQ-019 SHALL provide port: mispredict_count  output  16  number of mispredictions since reset.

Function
REQ-020 SHALL hold a table of 2**IDX_W 2-bit saturating counters indexed by address bits [IDX_W-1:0].
REQ-021 SHALL implement an FSM with states IDLE, UPDATE and FLUSH_WAIT.
REQ-022 SHALL drive resolve_ready = (state == IDLE).
REQ-023 SHALL drive predict_ready = (state == IDLE) and not resolve_valid, so that resolve wins a same-cycle conflict.
REQ-024 SHALL, on an accepted prediction, register predict_valid = 1 and predict_taken = counter[idx] bit 1 at the next edge (latency 1), with predict_valid low in every other cycle.
REQ-025 SHALL, on an accepted resolve in IDLE, capture resolve_addr, resolve_target, resolve_taken and resolve_pred, then move to UPDATE.
REQ-026 SHALL, in UPDATE, increment the indexed counter when taken and decrement it when not taken, saturating at 3 and at 0.
REQ-027 SHALL, in UPDATE, return to IDLE when captured taken == captured pred.
REQ-028 SHALL, in UPDATE, on a mismatch, set flush = 1, set redirect_addr to either captured target (taken) or captured addr + 1 modulo 2**ADDR_W (not taken), increment mispredict_count, and move to FLUSH_WAIT.
REQ-029 SHALL saturate mispredict_count at 0xFFFF.
REQ-030 SHALL hold flush and redirect_addr stable in FLUSH_WAIT until flush_ack is sampled high, then clear flush and enter IDLE at that edge.
REQ-031 SHALL ignore flush_ack outside FLUSH_WAIT.
REQ-032 SHALL ignore predict_req and resolve_valid while their ready is low; the requester holds them.
REQ-033 SHALL read the pre-update counter value when a prediction and an UPDATE write target the same index in the same cycle (write takes effect next cycle).

Reset
REQ-034 SHALL, while reset_n is low, immediately force state = IDLE, every counter = 2'b01, predict_valid = 0, predict_taken = 0, flush = 0, redirect_addr = 0 and mispredict_count = 0, including mid-UPDATE and mid-FLUSH_WAIT.
REQ-035 SHALL accept requests from the first rising edge after reset_n goes high.

Verification
REQ-036 SHALL cover cold predict: after reset, predict_req with addr 0x005 -> predict_valid pulse one cycle later, predict_taken = 0.
REQ-037 SHALL cover training: three resolves of addr 0x005 taken, pred 1 -> counter 01→10→11→11, no flush, predict at 0x005 gives taken = 1.
REQ-038 SHALL cover misprediction: resolve addr 0x7FF, taken 0, pred 1 -> flush high, redirect_addr 0x000, mispredict_count +1, flush held until flush_ack, IDLE the cycle after.
REQ-039 SHALL cover taken mispredict: resolve addr 0x010, target 0x2A0, taken 1, pred 0 -> redirect_addr 0x2A0.
REQ-040 SHALL cover conflict: predict_req and resolve_valid in the same IDLE cycle -> resolve_ready = 1, predict_ready = 0, prediction accepted only after return to IDLE.
REQ-041 SHALL cover reset in FLUSH_WAIT: reset_n low -> flush 0 asynchronously, all counters back to 01, mispredict_count 0.
